// File: rtl/fifo_traffic_gen.sv
// Write-side FIFO traffic generator: bursts of channel-tagged words separated by
// programmable gaps, with per-channel sequence counters and transfer/stall counters.
module fifo_traffic_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int CHANNELS   = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  w_clk,
  input  logic                  nRST,
  input  logic                  START,
  input  logic                  ABORT,
  input  logic [1:0]            MODE,
  input  logic [CNT_WIDTH-1:0]  BURST_LEN,
  input  logic [CNT_WIDTH-1:0]  GAP_LEN,
  input  logic [CNT_WIDTH-1:0]  BURST_CNT,
  output logic                  W_nEN,
  output logic [DATA_WIDTH-1:0] W_DATA,
  input  logic                  W_FULL,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [CNT_WIDTH-1:0]  WORD_CNT,
  output logic [CNT_WIDTH-1:0]  STALL_CNT
);

  localparam int CH_BITS = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int PW      = DATA_WIDTH - CH_BITS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_GAP,
    S_FIN
  } state_t;

  state_t                state_q, state_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [CNT_WIDTH-1:0]  word_cnt_q, word_cnt_d;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0]  beats_left_q, beats_left_d;
  logic [CNT_WIDTH-1:0]  bursts_left_q, bursts_left_d;
  logic [CNT_WIDTH-1:0]  gap_cnt_q, gap_cnt_d;
  logic [CNT_WIDTH-1:0]  burst_len_q, burst_len_d;
  logic [CNT_WIDTH-1:0]  gap_len_q, gap_len_d;
  logic [1:0]            mode_q, mode_d;
  logic [CH_BITS-1:0]    ch_q, ch_d;
  logic [PW-1:0]         seq_q [CHANNELS];
  logic [PW-1:0]         seq_d [CHANNELS];
  logic [DATA_WIDTH-1:0] hold_q, hold_d;

  logic                  xfer;
  logic                  stall;
  logic [PW-1:0]         seq_cur;
  logic [PW-1:0]         payload;
  logic [CH_BITS-1:0]    ch_next;
  logic [CNT_WIDTH-1:0]  len_eff;
  logic [CNT_WIDTH-1:0]  start_len;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_comb begin
    xfer      = (state_q == S_BURST) && !W_FULL;
    stall     = (state_q == S_BURST) && W_FULL;
    len_eff   = (burst_len_q == '0) ? CNT_WIDTH'(1) : burst_len_q;
    start_len = (BURST_LEN == '0) ? CNT_WIDTH'(1) : BURST_LEN;
    ch_next   = (ch_q == CH_BITS'(CHANNELS - 1)) ? '0 : ch_q + 1'b1;
  end

  // Payload pattern is a pure function of the active channel's registered counter.
  always_comb begin
    seq_cur = seq_q[ch_q];
    payload = '0;
    case (mode_q)
      2'd0:    payload = seq_cur;
      2'd1:    payload = ~seq_cur;
      2'd2:    payload = seq_cur ^ (seq_cur >> 1);
      default: payload = '0;
    endcase
  end

  always_comb begin
    W_nEN  = (state_q != S_BURST);
    W_DATA = W_nEN ? hold_q : {ch_q, payload};
    hold_d = W_DATA;
  end

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q;
    done_d        = done_q;
    word_cnt_d    = word_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    beats_left_d  = beats_left_q;
    bursts_left_d = bursts_left_q;
    gap_cnt_d     = gap_cnt_q;
    burst_len_d   = burst_len_q;
    gap_len_d     = gap_len_q;
    mode_d        = mode_q;
    ch_d          = ch_q;
    for (int i = 0; i < CHANNELS; i++) seq_d[i] = seq_q[i];

    // The word offered in an aborting cycle still lands in the FIFO, so it is counted.
    if (xfer) begin
      seq_d[ch_q] = seq_q[ch_q] + 1'b1;
      word_cnt_d  = sat_inc(word_cnt_q);
    end
    if (stall) stall_cnt_d = sat_inc(stall_cnt_q);

    case (state_q)
      S_IDLE: begin
        if (START && !ABORT) begin
          mode_d        = MODE;
          burst_len_d   = BURST_LEN;
          gap_len_d     = GAP_LEN;
          bursts_left_d = BURST_CNT;
          beats_left_d  = start_len;
          ch_d          = '0;
          done_d        = 1'b0;
          word_cnt_d    = '0;
          stall_cnt_d   = '0;
          for (int i = 0; i < CHANNELS; i++) seq_d[i] = '0;
          if (BURST_CNT == '0) begin
            state_d = S_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d = S_BURST;
            busy_d  = 1'b1;
          end
        end
      end
      S_BURST: begin
        if (ABORT) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (xfer) begin
          if (beats_left_q == CNT_WIDTH'(1)) begin
            if (bursts_left_q == CNT_WIDTH'(1)) begin
              state_d = S_FIN;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              ch_d          = ch_next;
              bursts_left_d = bursts_left_q - 1'b1;
              beats_left_d  = len_eff;
              if (gap_len_q != '0) begin
                state_d   = S_GAP;
                gap_cnt_d = gap_len_q - 1'b1;
              end
            end
          end else begin
            beats_left_d = beats_left_q - 1'b1;
          end
        end
      end
      S_GAP: begin
        if (ABORT) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else if (gap_cnt_q == '0) begin
          state_d = S_BURST;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end
      S_FIN: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge w_clk or negedge nRST) begin
    if (!nRST) begin
      state_q       <= S_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      word_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      beats_left_q  <= '0;
      bursts_left_q <= '0;
      gap_cnt_q     <= '0;
      burst_len_q   <= '0;
      gap_len_q     <= '0;
      mode_q        <= '0;
      ch_q          <= '0;
      hold_q        <= '0;
      for (int i = 0; i < CHANNELS; i++) seq_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      word_cnt_q    <= word_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      beats_left_q  <= beats_left_d;
      bursts_left_q <= bursts_left_d;
      gap_cnt_q     <= gap_cnt_d;
      burst_len_q   <= burst_len_d;
      gap_len_q     <= gap_len_d;
      mode_q        <= mode_d;
      ch_q          <= ch_d;
      hold_q        <= hold_d;
      for (int i = 0; i < CHANNELS; i++) seq_q[i] <= seq_d[i];
    end
  end

  assign BUSY      = busy_q;
  assign DONE      = done_q;
  assign WORD_CNT  = word_cnt_q;
  assign STALL_CNT = stall_cnt_q;

endmodule

// File: doc/fifo_traffic_gen.md
Name: fifo_traffic_gen

Overview:
- Parametrised write-side traffic generator for FIFO benches, running in the w_clk domain.
- Drives a FIFO push interface (active-low enable, full back-pressure) with programmable bursts, gaps and data patterns.
- Interleaves multiple logical channels and tags each word with its channel ID so a read-side checker can verify ordering per channel.
- Reports transfer and stall counts.

Parameters:
DATA_WIDTH, 32, width of W_DATA (>= CH_BITS+4)
CHANNELS, 4, number of logical channels, power of 2, 1..16
CNT_WIDTH, 16, width of BURST_LEN, GAP_LEN, BURST_CNT, WORD_CNT, STALL_CNT
CH_BITS (derived), max(1,clog2(CHANNELS)), channel tag width in W_DATA MSBs

Ports:
w_clk  input  1  clock
nRST  input  1  asynchronous active-low reset
START  input  1  pulse; latches config and begins a run when idle
ABORT  input  1  synchronous stop, returns to idle
MODE  input  2  payload pattern: 0 increment, 1 inverted increment, 2 Gray of increment, 3 = 0
BURST_LEN  input  CNT_WIDTH  words per burst (0 treated as 1)
GAP_LEN  input  CNT_WIDTH  idle cycles between bursts
BURST_CNT  input  CNT_WIDTH  bursts per run
W_nEN  output  1  push enable, active low
W_DATA  output  DATA_WIDTH  {channel tag, payload}
W_FULL  input  1  FIFO full
BUSY  output  1  run in progress
DONE  output  1  sticky, run completed normally
WORD_CNT  output  CNT_WIDTH  words transferred this run
STALL_CNT  output  CNT_WIDTH  cycles with W_nEN=0 and W_FULL=1

Behaviour:
- Reset values: W_nEN=1, W_DATA=0, BUSY=0, DONE=0, WORD_CNT=0, STALL_CNT=0. Reset is FSM IDLE, all per-channel sequence counters 0.
- Transfer occurs in a cycle when W_nEN==0 and W_FULL==0. W_DATA holds stable while W_nEN==0 and W_FULL==1.
- States:
  - IDLE: START=1 latches MODE, BURST_LEN, GAP_LEN and BURST_CNT. Clears DONE, WORD_CNT, STALL_CNT and all channel counters. Sets BUSY=1 next cycle.
    - If BURST_CNT==0, goes directly to FIN.
    - Otherwise goes to BURST with channel 0. W_nEN=0 from the cycle after START.
  - BURST: W_nEN=0. Each transfer increments that channel's counter and WORD_CNT. After the BURST_LEN-th transfer of the burst:
    - if it is the last burst, go to FIN;
    - else if GAP_LEN>0, go to GAP;
    - else stay in BURST with the next channel; W_nEN stays 0 with no bubble.
  - GAP: W_nEN=1 for exactly GAP_LEN cycles, then BURST with the next channel.
  - FIN: one cycle with W_nEN=1, BUSY=0, DONE=1, then IDLE.
- Channel selection: burst k (0-based) uses channel k mod CHANNELS. Wraps after CHANNELS-1.
- W_DATA:
  - MSB CH_BITS hold the channel.
  - The low DATA_WIDTH-CH_BITS bits hold f(seq), where seq is the channel's counter, truncated and wrapping modulo 2^(DATA_WIDTH-CH_BITS).
  - f = seq (mode 0), ~seq (mode 1), seq^(seq>>1) (mode 2).
  - W_DATA updates combinationally from the registered counter, so the new value is valid in the cycle after each transfer.
  - When W_nEN=1, W_DATA holds its last value.
- Counters saturate: WORD_CNT and STALL_CNT stick at all-ones and do not wrap.
- START while BUSY=1 is ignored.
- START and ABORT asserted in the same cycle: ABORT wins.
- ABORT in any non-IDLE state: W_nEN=1 and BUSY=0 next cycle, state IDLE, DONE stays 0, counters keep their values for readout.
- Config inputs are ignored except in the START cycle.
- W_FULL asserted for the whole burst: generator waits indefinitely; STALL_CNT counts every waiting cycle.
- nRST low mid-run: all outputs return to reset values immediately (asynchronous); no partial transfer is reported.

Test Plan:
1. CHANNELS=4, MODE=0, BURST_LEN=3, GAP_LEN=0, BURST_CNT=4, W_FULL=0 -> 12 contiguous transfers: 0x00000000, 0x00000001, 0x00000002, then 0x40000000..0x40000002, 0x80000000..0x80000002, 0xC0000000..0xC0000002. DONE=1 and WORD_CNT=12 one cycle after the last transfer; BUSY low in the FIN cycle.
2. Same config with BURST_CNT=5, GAP_LEN=2 -> W_nEN=1 for exactly 2 cycles between bursts. Fifth burst is channel 0 with payloads 3, 4, 5.
3. MODE=2, BURST_LEN=4, BURST_CNT=1, W_FULL=1 on the 2nd and 3rd cycles of W_nEN=0 -> payloads 0, 1, 3, 2; data held during stall; STALL_CNT=2, WORD_CNT=4.
4. ABORT two cycles into a run of BURST_LEN=8 -> W_nEN=1 next cycle, BUSY=0, DONE=0, WORD_CNT=2. A following START clears the counters and restarts at channel 0, payload 0.
5. BURST_CNT=0 START -> no transfers, DONE=1 after 2 cycles. BURST_LEN=0, BURST_CNT=2 -> exactly 2 transfers. START during BUSY -> no effect.
6. Drive into a 2-deep FiFo_Async with read clock 20 ns and write clock 30 ns. Read-side checker confirms per-channel sequences, MODE=1 inverted values, and no loss or duplication across 1000 words. Assert nRST mid-burst -> W_nEN=1 immediately.
